// File: rtl/xbar_pkg.sv
// Shared sizing helpers for the crossbar and its request scheduler.
package xbar_pkg;

  localparam int unsigned NumElemDef = 5;

  // Index width for n elements; a single element still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IdxWDef = idx_width(NumElemDef);

  typedef logic [IdxWDef-1:0] idx_t;

endpackage

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter for one crossbar destination; the pointer names the
// requester with highest priority next cycle and moves just past each winner.
module xbar_rr_arb
  import xbar_pkg::*;
#(
  parameter int unsigned NumElem = 5,
  parameter int unsigned IdxW    = idx_width(NumElem)
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NumElem-1:0] req_i,
  input  logic               en_i,
  output logic [NumElem-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NumElem-1:0] gnt_d;
  logic [IdxW-1:0]    idx_d;
  logic               found;
  int                 cand;
  logic [IdxW-1:0]    cand_idx;

  always_comb begin
    gnt_d    = '0;
    idx_d    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    ptr_d    = ptr_q;
    for (int k = 0; k < int'(NumElem); k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NumElem)) cand = cand - int'(NumElem);
      cand_idx = IdxW'(cand);
      if (!found && en_i && req_i[cand_idx]) begin
        found          = 1'b1;
        gnt_d[cand_idx] = 1'b1;
        idx_d          = cand_idx;
      end
    end
    if (found) begin
      ptr_d = (idx_d == IdxW'(NumElem - 1)) ? '0 : idx_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign gnt_o = gnt_d;
  assign idx_o = idx_d;

endmodule

// File: rtl/xbar_sched.sv
// Registered request scheduler feeding xbar: per-destination round-robin
// arbitration, then registered source words, select codes and valid flags.
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int unsigned NumElem   = 5,
  parameter int unsigned ElemWidth = 4,
  localparam int unsigned IdxW     = idx_width(NumElem)
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NumElem-1:0]                  req_valid_i,
  input  logic [NumElem-1:0][IdxW-1:0]        req_dest_i,
  input  logic [NumElem-1:0][ElemWidth-1:0]   req_data_i,
  output logic [NumElem-1:0]                  req_ready_o,
  output logic [NumElem-1:0][ElemWidth-1:0]   data_o,
  output logic [NumElem-1:0][IdxW-1:0]        select_o,
  output logic [NumElem-1:0]                  valid_o,
  output logic                                err_o
);

  logic [NumElem-1:0] req_vec [NumElem];
  logic [NumElem-1:0] gnt     [NumElem];
  logic [IdxW-1:0]    gnt_idx [NumElem];
  logic [NumElem-1:0] illegal;
  logic [NumElem-1:0] won;

  logic [NumElem-1:0][ElemWidth-1:0] data_q, data_d;
  logic [NumElem-1:0][IdxW-1:0]      select_q, select_d;
  logic [NumElem-1:0]                valid_q, valid_d;
  logic                              err_q, err_d;

  // Row j of req_vec is the set of sources aiming at destination j.
  always_comb begin
    for (int j = 0; j < int'(NumElem); j++) begin
      req_vec[j] = '0;
      for (int i = 0; i < int'(NumElem); i++) begin
        req_vec[j][i] = req_valid_i[i] && (req_dest_i[i] == IdxW'(j));
      end
    end
    for (int i = 0; i < int'(NumElem); i++) begin
      illegal[i] = req_valid_i[i] && (32'(req_dest_i[i]) >= NumElem);
    end
  end

  for (genvar j = 0; j < int'(NumElem); j++) begin : g_arb
    xbar_rr_arb #(
      .NumElem (NumElem),
      .IdxW    (IdxW)
    ) u_arb (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .req_i   (req_vec[j]),
      .en_i    (1'b1),
      .gnt_o   (gnt[j]),
      .idx_o   (gnt_idx[j])
    );
  end

  always_comb begin
    won = '0;
    for (int j = 0; j < int'(NumElem); j++) begin
      won = won | gnt[j];
    end
  end

  assign req_ready_o = won | illegal;

  always_comb begin
    data_d   = data_q;
    select_d = select_q;
    valid_d  = '0;
    err_d    = |illegal;
    // Out-of-range requests never win an arbiter, so won excludes them.
    for (int i = 0; i < int'(NumElem); i++) begin
      if (won[i]) data_d[i] = req_data_i[i];
    end
    for (int j = 0; j < int'(NumElem); j++) begin
      if (|gnt[j]) begin
        valid_d[j]  = 1'b1;
        select_d[j] = gnt_idx[j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_q   <= '0;
      select_q <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign data_o   = data_q;
  assign select_o = select_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_xbar_sched.sv
// Self-checking bench for xbar_sched: directed scenarios plus randomized
// held-until-accepted traffic compared against a cycle-level reference model.
module tb_xbar_sched;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid;
  logic [N-1:0][IW-1:0] req_dest;
  logic [N-1:0][W-1:0]  req_data;
  logic [N-1:0]         req_ready_o;
  logic [N-1:0][W-1:0]  data_o;
  logic [N-1:0][IW-1:0] select_o;
  logic [N-1:0]         valid_o;
  logic                 err_o;

  xbar_sched #(.NumElem(N), .ElemWidth(W)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (req_valid),
    .req_dest_i  (req_dest),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .data_o      (data_o),
    .select_o    (select_o),
    .valid_o     (valid_o),
    .err_o       (err_o)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scheduler state as plain integers and words.
  int           m_ptr  [N];
  int           m_sel  [N];
  logic [W-1:0] m_data [N];
  logic [N-1:0] m_valid;
  logic         m_err;
  logic [N-1:0] m_acc;

  // Winner for destination j: first requester at or after the pointer, cyclically.
  function automatic int win(input int j);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr[j] + k) % N;
      if (req_valid[c] && int'(req_dest[c]) == j) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (int'(req_dest[i]) >= N) r[i] = 1'b1;
        else if (win(int'(req_dest[i])) == i) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic m_any_illegal();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && int'(req_dest[i]) >= N) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int j = 0; j < N; j++) begin
        m_ptr[j]  <= 0;
        m_sel[j]  <= 0;
        m_data[j] <= '0;
      end
      m_valid <= '0;
      m_err   <= 1'b0;
      m_acc   <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (win(j) >= 0) begin
          m_sel[j]        <= win(j);
          m_valid[j]      <= 1'b1;
          m_data[win(j)]  <= req_data[win(j)];
          m_ptr[j]        <= (win(j) + 1) % N;
        end else begin
          m_valid[j] <= 1'b0;
        end
      end
      m_err <= m_any_illegal();
      m_acc <= m_ready();
    end
  end

  always @(negedge clk) begin
    if (cmp_en && arst_n) begin
      check("ready", 64'(req_ready_o), 64'(m_ready()));
      check("valid", 64'(valid_o), 64'(m_valid));
      check("err", 64'(err_o), 64'(m_err));
      for (int i = 0; i < N; i++) begin
        check($sformatf("data[%0d]", i), 64'(data_o[i]), 64'(m_data[i]));
        check($sformatf("select[%0d]", i), 64'(select_o[i]), 64'(m_sel[i]));
      end
    end
  end

  task automatic set_req(input int i, input logic v, input int d, input int dat);
    req_valid[i] = v;
    req_dest[i]  = IW'(d);
    req_data[i]  = W'(dat);
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_dest  = '0;
    req_data  = '0;
  endtask

  int exp_w [4] = '{0, 1, 3, 0};

  initial begin
    arst_n = 1'b0;
    clear_req();

    // Reset held with random traffic: everything stays zero.
    repeat (3) begin
      @(posedge clk); #2;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_req(i, req_valid[i], $urandom_range(0, 7), $urandom);
    end
    @(negedge clk);
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_select", 64'(select_o), 64'(0));
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    clear_req();
    arst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 64'(valid_o), 64'(0));
    check("idle_data", 64'(data_o), 64'(0));

    // Single request: source 2 -> destination 4.
    @(posedge clk); #2;
    set_req(2, 1'b1, 4, 'hA);
    @(negedge clk);
    check("single_ready", 64'(req_ready_o), 64'b00100);
    @(posedge clk); #2;
    clear_req();
    check("single_valid", 64'(valid_o), 64'b10000);
    check("single_sel4", 64'(select_o[4]), 64'd2);
    check("single_data2", 64'(data_o[2]), 64'hA);
    check("model_sel4", 64'(m_sel[4]), 64'd2);

    // Contention on destination 1: sources 0, 1, 3; source 0 keeps requesting.
    set_req(0, 1'b1, 1, 1);
    set_req(1, 1'b1, 1, 2);
    set_req(3, 1'b1, 1, 3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("cont_ready", 64'(req_ready_o), 64'(1) << exp_w[c]);
      @(posedge clk); #2;
      check("cont_valid1", 64'(valid_o[1]), 64'd1);
      check("cont_sel1", 64'(select_o[1]), 64'(exp_w[c]));
      if (exp_w[c] == 1) req_valid[1] = 1'b0;
      if (exp_w[c] == 3) req_valid[3] = 1'b0;
    end
    check("model_ptr1", 64'(m_ptr[1]), 64'd1);
    clear_req();

    // Full permutation: source i -> destination (i+1)%5 with data i+8.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, (i + 1) % N, i + 8);
    @(negedge clk);
    check("perm_ready", 64'(req_ready_o), 64'b11111);
    @(posedge clk); #2;
    clear_req();
    check("perm_valid", 64'(valid_o), 64'b11111);
    for (int j = 0; j < N; j++) begin
      check("perm_sel", 64'(select_o[j]), 64'((j + 4) % N));
      check("perm_xbar", 64'(data_o[select_o[j]]), 64'(((j + 4) % N) + 8));
    end

    // Out-of-range destination is accepted and discarded.
    set_req(0, 1'b1, 6, 'h3);
    @(negedge clk);
    check("illegal_ready", 64'(req_ready_o), 64'b00001);
    @(posedge clk); #2;
    clear_req();
    check("illegal_err", 64'(err_o), 64'd1);
    check("illegal_valid", 64'(valid_o), 64'd0);
    check("illegal_data0", 64'(data_o[0]), 64'h8);
    @(posedge clk); #2;
    check("err_clears", 64'(err_o), 64'd0);

    // Asynchronous reset in the middle of contention.
    set_req(0, 1'b1, 1, 4);
    set_req(1, 1'b1, 1, 5);
    set_req(3, 1'b1, 1, 6);
    @(posedge clk); #2;
    @(posedge clk); #4;
    check("pre_rst_valid", 64'(valid_o[1]), 64'd1);
    arst_n = 1'b0;
    #1;
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_select", 64'(select_o), 64'd0);
    check("arst_data", 64'(data_o), 64'd0);
    check("arst_err", 64'(err_o), 64'd0);
    @(negedge clk);
    @(posedge clk); #3;
    arst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready_o), 64'b00001);
    @(posedge clk); #2;
    check("post_rst_sel1", 64'(select_o[1]), 64'd0);
    check("post_rst_valid", 64'(valid_o), 64'b00010);
    clear_req();

    // Randomized traffic; each request holds until the model says it was accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 9) == 0) set_req(i, 1'b1, $urandom_range(5, 7), $urandom);
            else                           set_req(i, 1'b1, $urandom_range(0, 4), $urandom);
          end else begin
            set_req(i, 1'b0, $urandom_range(0, 7), $urandom);
          end
        end
      end
      if (cyc % 700 == 350) begin
        #1 arst_n = 1'b0;
        #3 arst_n = 1'b1;
      end
    end

    @(posedge clk); #2;
    clear_req();
    repeat (3) @(negedge clk);
    check("final_valid", 64'(valid_o), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_sched.md
# xbar_sched

Registered request scheduler that sits directly upstream of the combinational `xbar`. Each of `NumElem` sources presents a valid/ready request carrying a destination index and a data word. Per destination, a round-robin arbiter picks one winner per cycle. The block then registers the winning data words, the per-output select codes and the per-output valid flags, which feed `xbar` `inputs_i`/`select_i` with one cycle of latency.

## Interface
- `NumElem`, default 5: number of sources and destinations (≥2); index width `IdxW = $clog2(NumElem)`.
- `ElemWidth`, default 4: data word width.

Ports:
- `clk_i` input 1: clock; all state updates on rising edge.
- `arst_ni` input 1: asynchronous, active-low reset.
- `req_valid_i` input `[NumElem]`: source i has a request.
- `req_dest_i` input `[NumElem][IdxW]`: destination index for source i.
- `req_data_i` input `[NumElem][ElemWidth]`: data word for source i.
- `req_ready_o` output `[NumElem]`: source i's request is accepted this cycle.
- `data_o` output `[NumElem][ElemWidth]`: registered source words; connects to `xbar.inputs_i`.
- `select_o` output `[NumElem][IdxW]`: registered source index per destination; connects to `xbar.select_i`.
- `valid_o` output `[NumElem]`: destination j carries a freshly granted word this cycle.
- `err_o` output 1: pulses when an out-of-range destination request was accepted in the previous cycle.

## Operation
- Request i targets destination j when `req_valid_i[i]` is high and `req_dest_i[i]==j`, with j < NumElem.
- Each destination j has one arbiter with a pointer `ptr[j]`.
  - The winner is the first targeting source at or after `ptr[j]`, searching cyclically upward with wrap from NumElem-1 to 0.
  - After a grant to source i: `ptr[j] <= (i+1)` when i < NumElem-1, else 0.
  - With no grant, `ptr[j]` holds.
- `req_ready_o[i]` is combinational and high iff source i wins its destination, or its destination is ≥ NumElem.
  - Ready depends on valid. A source must not wait for ready before asserting valid.
  - A request that is not accepted must hold valid, dest and data unchanged until accepted.
- Out-of-range destination (only possible when NumElem is not a power of two):
  - the request is accepted and discarded;
  - `err_o` is high on the next cycle;
  - no `valid_o` bit is set for it;
  - `data_o[i]` is not updated.
- On a handshake at source i with legal destination j:
  - `data_o[i] <= req_data_i[i]`
  - `select_o[j] <= i`
  - `valid_o[j] <= 1`
- Destinations without a grant: `valid_o[j] <= 0`, and `select_o[j]` holds.
- `data_o[i]` holds whenever source i is not accepted.
- Simultaneous events:
  - Different destinations are independent, so up to NumElem grants can occur in one cycle; a full permutation completes in one cycle.
  - Each source requests exactly one destination, so no source can win twice.
- Reset values: all pointers 0; `data_o` 0, `select_o` 0, `valid_o` 0, `err_o` 0.
- `req_ready_o` is combinational, so it is 0 whenever `req_valid_i` is 0.

## Timing
- Arbitration and `req_ready_o` are combinational from the current `req_*` and pointer state.
- Handshake at edge k → `data_o`/`select_o`/`valid_o`/`err_o` are valid after edge k, throughout cycle k+1.
- The `xbar` output for destination j is meaningful only when `valid_o[j]` is high.
- Throughput: one grant per destination per cycle, with no bubbles.
- Reset asserted mid-operation:
  - all registers clear immediately (asynchronously);
  - in-flight grants are lost;
  - after release, the first grant for each destination goes to the lowest-index requester.
- Requests are ignored while `arst_ni` is low.

## Structure
- Package `xbar_pkg`: localparam helper for `IdxW` and a typedef for the index type. Shared with `xbar` and testbenches.
- Sub-module `xbar_rr_arb`: one round-robin arbiter.
  - Inputs: request vector `[NumElem]`, grant-enable.
  - Output: one-hot grant plus encoded index.
  - Owns its own pointer register.
  - `xbar_sched` instantiates NumElem copies in a generate loop.
- The top level holds the per-source request decode, the data/select/valid registers and the `err_o` flag.

## Test plan
- Reset: hold `arst_ni`=0 with random requests → `data_o`, `select_o`, `valid_o`, `err_o` all 0. After release with no requests, outputs stay 0.
- Single request: source 2, dest 4, data 0xA → `req_ready_o`=5'b00100 in the same cycle. Next cycle: `valid_o`=5'b10000, `select_o[4]`=2, `data_o[2]`=0xA.
- Contention and wrap: sources 0, 1, 3 all target dest 1 and are held until accepted; source 0 re-requests after its grant.
  - Grants occur in order 0, 1, 3, then 0 (pointer wrapped via 4).
  - `valid_o[1]`=1 on each following cycle.
- Full permutation: all five sources valid with dest (i+1)%5 and data i+8 → all ready in one cycle. Next cycle: `valid_o`=5'b11111, `select_o[j]`=(j+4)%5, and `xbar` output j = ((j+4)%5)+8.
- Illegal destination: source 0 with dest 6 → `req_ready_o[0]`=1. Next cycle: `err_o`=1, `valid_o`=0, `data_o[0]` unchanged.
- Reset mid-contention: pulse `arst_ni` low during the contention scenario → outputs clear without waiting for a clock edge. After release, the first grant for dest 1 goes to source 0.
